if_fetch_buffer: RTL
====================

Name: if_fetch_buffer

Overview:
- Fetch stage directly downstream of the instruction cache, also its address source.
- Holds the fetch PC and drives proc2Icache_addr/command each cycle.
- Splits each returned 64-bit word into two 32-bit instructions, queues them with their PCs, and presents up to 2 per cycle to dispatch.
- Flushes on branch_mispredict and redirects to pc_target.

Parameters:
IB_DEPTH, 8, instruction queue entries; power of 2, >= 4
IB_PTR_W, $clog2(IB_DEPTH), queue pointer width; count width is IB_PTR_W+1

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
branch_mispredict  in  1  flush queue, redirect fetch
pc_target  in  64  redirect PC, valid with branch_mispredict
Icache2proc_data  in  64  instruction word for the current proc2Icache_addr
Icache2proc_valid  in  1  Icache2proc_data valid this cycle
proc2Icache_addr  out  64  8-byte-aligned fetch address
proc2Icache_command  out  BUS_COMMAND  BUS_LOAD when fetching, else BUS_NONE
dispatch_take  in  2  instructions consumed by dispatch this cycle (0..2)
inst_out_0  out  32  oldest queued instruction
inst_out_1  out  32  second oldest queued instruction
pc_out_0  out  64  PC of inst_out_0
pc_out_1  out  64  PC of inst_out_1
inst_valid_0  out  1  inst_out_0 valid
inst_valid_1  out  1  inst_out_1 valid
ib_count  out  IB_PTR_W+1  current queue occupancy

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high. No other resets or clocks.
- State:
  - fetch_pc (64b).
  - Circular queue: IB_DEPTH entries of {inst[31:0], pc[63:0]}.
  - head, tail pointers; count.
- Reset values:
  - fetch_pc = 0; head = tail = count = 0.
  - Outputs: inst_valid_0/1 = 0, inst_out_0/1 = NOOP_INST (32'h47ff041f), pc_out_0/1 = 0, ib_count = 0.
  - proc2Icache_command = BUS_NONE during the reset cycle.
- Fetch request (combinational from registered state):
  - proc2Icache_addr = {fetch_pc[63:3], 3'b000}.
  - proc2Icache_command = BUS_LOAD iff !reset && !branch_mispredict && (IB_DEPTH - count) >= 2; else BUS_NONE.
- Push, in a cycle where command == BUS_LOAD and Icache2proc_valid == 1:
  - fetch_pc[2] == 0: push Icache2proc_data[31:0] @ addr, then Icache2proc_data[63:32] @ addr+4 (2 entries).
  - fetch_pc[2] == 1: push Icache2proc_data[63:32] @ addr+4 only (misaligned redirect entry).
  - fetch_pc <= addr + 8.
- Miss (command == BUS_LOAD, valid == 0): fetch_pc holds. The same address is re-presented next cycle; the cache's prefetch/miss handling is transparent to this block.
- Pop:
  - Outputs show entries head and head+1; inst_valid_0 = (count >= 1), inst_valid_1 = (count >= 2).
  - Invalid slots show NOOP_INST and pc 0.
  - head advances by dispatch_take.
  - dispatch_take greater than the number of valid outputs, or equal to 3, is illegal: assertion fires, and the pop is clamped to the valid count.
- Simultaneous push and pop in one cycle:
  - count_next = count + pushed − popped.
  - Pop reads pre-push state; a just-pushed entry is never output in the same cycle (1-cycle minimum cache-to-dispatch latency).
- Wrap-around: pointer arithmetic modulo IB_DEPTH; a 2-entry push may straddle the wrap.
- Full: the push threshold guarantees no overflow. Count never exceeds IB_DEPTH; assertion.
- branch_mispredict (highest priority after reset):
  - Same cycle: proc2Icache_command = BUS_NONE, cache data ignored, dispatch_take ignored.
  - Next edge: head = tail = count = 0, fetch_pc <= pc_target.
  - Following cycle: inst_valid_0/1 = 0; fetch resumes at {pc_target[63:3],3'b0}.
- Reset asserted mid-operation: all state returns to reset values on that edge, regardless of mispredict, push or pop.

Decomposition:
- sys_defs package:
  - BUS_COMMAND enum (existing, shared with mem and icache).
  - NOOP_INST constant.
  - IB_DEPTH default.
- One natural sub-module, if_inst_fifo:
  - 2-write/2-read circular queue with count and flush.
  - if_fetch_buffer keeps the PC, request and alignment logic.

Test Plan:
- Reset then cache always hits with data = 64'h2222_2222_1111_1111:
  - First request addr = 0.
  - Next cycle inst_valid_0/1 = 1, inst_out_0 = 32'h1111_1111 pc 0, inst_out_1 = 32'h2222_2222 pc 4.
  - Then addr = 8.
- dispatch_take = 0 with cache always hitting:
  - Pushes continue until count = IB_DEPTH (8), then command = BUS_NONE.
  - dispatch_take = 2 for one cycle → count 6 next cycle, BUS_LOAD resumes.
- Mispredict with pc_target = 64'h104 while count = 5:
  - Next cycle count = 0, inst_valid_0 = 0, addr = 64'h100.
  - On hit, exactly one entry pushed: Icache2proc_data[63:32] with pc 64'h104; then addr = 64'h108.
- Icache2proc_valid low for 3 cycles (miss): addr held at 64'h40 for all 3 cycles, no push; on the 4th cycle valid = 1 → two pushes, addr 64'h48.
- Wrap-around: head = tail = 7, count = 0, push 2 (entries 7, 0), next cycle take 1 → inst_out_0 = entry 0 contents, count 1, head = 0.
- Simultaneous: count = 1, hit pushes 2, take 1 in same cycle → count 2; outputs the two pushed instructions in order next cycle.

Source files
------------

// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the fetch stage: bus command encoding, the no-op
// instruction and the default instruction-queue depth.
package if_fetch_buffer_pkg;

    // Command encoding shared with the memory and instruction-cache blocks
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    // Shown on dispatch slots that hold no valid instruction
    localparam logic [31:0] NOOP_INST = 32'h47ff041f;

    // Default instruction-queue depth (power of two, at least 4)
    localparam int IB_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/if_inst_fifo.sv
// Circular instruction queue with two write ports and two read ports.
// Entries pair an instruction with its PC. A flush empties the queue in one
// cycle. Reads always reflect the state before the current cycle's writes.
module if_inst_fifo
    import if_fetch_buffer_pkg::*;
#(
    parameter int IB_DEPTH = IB_DEPTH_DEFAULT,
    parameter int IB_PTR_W = $clog2(IB_DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [1:0]          push_num,
    input  logic [31:0]         wr_inst_0,
    input  logic [31:0]         wr_inst_1,
    input  logic [63:0]         wr_pc_0,
    input  logic [63:0]         wr_pc_1,
    input  logic [1:0]          pop_req,
    output logic [31:0]         rd_inst_0,
    output logic [31:0]         rd_inst_1,
    output logic [63:0]         rd_pc_0,
    output logic [63:0]         rd_pc_1,
    output logic                rd_valid_0,
    output logic                rd_valid_1,
    output logic [IB_PTR_W:0]   count
);

    localparam logic [IB_PTR_W:0] CNT_TWO = (IB_PTR_W + 1)'(2);

    logic [31:0]         inst_mem [IB_DEPTH];
    logic [63:0]         pc_mem   [IB_DEPTH];
    logic [IB_PTR_W-1:0] head_q;
    logic [IB_PTR_W-1:0] tail_q;
    logic [IB_PTR_W-1:0] head_p1;
    logic [IB_PTR_W-1:0] tail_p1;
    logic [1:0]          avail;
    logic [1:0]          pop_num;

    assign head_p1 = head_q + IB_PTR_W'(1);
    assign tail_p1 = tail_q + IB_PTR_W'(1);

    // Limit the pop to the number of entries actually presented at the outputs
    always_comb begin
        avail   = (count >= CNT_TWO) ? 2'd2 : ((count == '0) ? 2'd0 : 2'd1);
        pop_num = (pop_req > avail) ? avail : pop_req;
    end

    // Write one or two entries at the tail; a 2-entry write may straddle the wrap
    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            if (push_num != 2'd0) begin
                inst_mem[tail_q] <= wr_inst_0;
                pc_mem[tail_q]   <= wr_pc_0;
            end
            if (push_num == 2'd2) begin
                inst_mem[tail_p1] <= wr_inst_1;
                pc_mem[tail_p1]   <= wr_pc_1;
            end
        end
    end

    // Advance pointers and occupancy; reset and flush both empty the queue
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            head_q <= head_q + IB_PTR_W'(pop_num);
            tail_q <= tail_q + IB_PTR_W'(push_num);
            count  <= count + (IB_PTR_W + 1)'(push_num) - (IB_PTR_W + 1)'(pop_num);
        end
    end

    assign rd_valid_0 = (count != '0);
    assign rd_valid_1 = (count >= CNT_TWO);
    assign rd_inst_0  = rd_valid_0 ? inst_mem[head_q]  : NOOP_INST;
    assign rd_inst_1  = rd_valid_1 ? inst_mem[head_p1] : NOOP_INST;
    assign rd_pc_0    = rd_valid_0 ? pc_mem[head_q]    : 64'd0;
    assign rd_pc_1    = rd_valid_1 ? pc_mem[head_p1]   : 64'd0;

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch stage sitting directly behind the instruction cache. Owns the fetch
// PC, issues one 8-byte cache request per cycle while the queue has room for
// a full word, splits returned words into two instructions and hands up to
// two per cycle to dispatch. A mispredict flushes and redirects fetch.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int IB_DEPTH = IB_DEPTH_DEFAULT,
    parameter int IB_PTR_W = $clog2(IB_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               branch_mispredict,
    input  logic [63:0]        pc_target,
    input  logic [63:0]        Icache2proc_data,
    input  logic               Icache2proc_valid,
    output logic [63:0]        proc2Icache_addr,
    output BUS_COMMAND         proc2Icache_command,
    input  logic [1:0]         dispatch_take,
    output logic [31:0]        inst_out_0,
    output logic [31:0]        inst_out_1,
    output logic [63:0]        pc_out_0,
    output logic [63:0]        pc_out_1,
    output logic               inst_valid_0,
    output logic               inst_valid_1,
    output logic [IB_PTR_W:0]  ib_count
);

    localparam logic [IB_PTR_W:0] PUSH_LIMIT = (IB_PTR_W + 1)'(IB_DEPTH - 2);
    localparam logic [IB_PTR_W:0] DEPTH_CNT  = (IB_PTR_W + 1)'(IB_DEPTH);

    logic [63:0] fetch_pc;
    logic [63:0] fetch_addr;
    logic        push;
    logic [1:0]  push_num;
    logic [31:0] wr_inst_0;
    logic [63:0] wr_pc_0;
    logic [1:0]  pop_req;
    logic [1:0]  avail_cnt;

    assign fetch_addr       = {fetch_pc[63:3], 3'b000};
    assign proc2Icache_addr = fetch_addr;

    // Request a word only when two free slots remain and no flush is pending
    always_comb begin
        proc2Icache_command = BUS_NONE;
        if (!reset && !branch_mispredict && (ib_count <= PUSH_LIMIT)) begin
            proc2Icache_command = BUS_LOAD;
        end
    end

    // A redirect into the upper half of a word keeps only the upper instruction
    always_comb begin
        push      = (proc2Icache_command == BUS_LOAD) && Icache2proc_valid;
        push_num  = push ? (fetch_pc[2] ? 2'd1 : 2'd2) : 2'd0;
        wr_inst_0 = fetch_pc[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];
        wr_pc_0   = fetch_pc[2] ? (fetch_addr + 64'd4) : fetch_addr;
        pop_req   = branch_mispredict ? 2'd0 : dispatch_take;
    end

    // Fetch PC: redirect on mispredict, step to the next word on a hit, hold on a miss
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= 64'd0;
        end else if (branch_mispredict) begin
            fetch_pc <= pc_target;
        end else if (push) begin
            fetch_pc <= fetch_addr + 64'd8;
        end
    end

    if_inst_fifo #(
        .IB_DEPTH (IB_DEPTH),
        .IB_PTR_W (IB_PTR_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (branch_mispredict),
        .push_num   (push_num),
        .wr_inst_0  (wr_inst_0),
        .wr_inst_1  (Icache2proc_data[63:32]),
        .wr_pc_0    (wr_pc_0),
        .wr_pc_1    (fetch_addr + 64'd4),
        .pop_req    (pop_req),
        .rd_inst_0  (inst_out_0),
        .rd_inst_1  (inst_out_1),
        .rd_pc_0    (pc_out_0),
        .rd_pc_1    (pc_out_1),
        .rd_valid_0 (inst_valid_0),
        .rd_valid_1 (inst_valid_1),
        .count      (ib_count)
    );

    assign avail_cnt = {inst_valid_1, inst_valid_0 & ~inst_valid_1};

    // Dispatch may never take more instructions than are presented
    a_take_legal : assert property (@(posedge clock) disable iff (reset)
        (branch_mispredict || (dispatch_take <= avail_cnt)));

    // The push threshold keeps the queue from overflowing
    a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        (ib_count <= DEPTH_CNT));

    // After consuming a word the fetch PC lands on the next 8-byte boundary
    a_pc_aligned : assert property (@(posedge clock) disable iff (reset)
        push |=> (fetch_pc[2:0] == 3'b000));

endmodule
